// File: rtl/irrigacao_pkg.sv
// Shared types and BCD limits for the ascending BCD stopwatch.
package irrigacao_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT    = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

  // A target is usable only if it is a legal mm:ss BCD time.
  function automatic logic target_valid(input logic [7:0] tmin, input logic [7:0] tsec);
    return (tmin[7:4] <= BCD_MAX_DIGIT) && (tmin[3:0] <= BCD_MAX_DIGIT) &&
           (tsec[7:4] <= BCD_MAX_SEC_TENS) && (tsec[3:0] <= BCD_MAX_DIGIT);
  endfunction

endpackage

// File: rtl/cronometro_bcd_crescente_if.sv
// Control/status bundle of the stopwatch; the master drives commands and targets.
interface cronometro_bcd_crescente_if;
  logic       tick;
  logic       start;
  logic       pause;
  logic       clear;
  logic [7:0] target_min;
  logic [7:0] target_sec;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       done_pulse;

  modport master (
    output tick, start, pause, clear, target_min, target_sec,
    input  min_bcd, sec_bcd, running, done, done_pulse
  );

  modport slave (
    input  tick, start, pause, clear, target_min, target_sec,
    output min_bcd, sec_bcd, running, done, done_pulse
  );
endinterface

// File: rtl/digito_bcd_crescente.sv
// One ascending BCD digit that wraps at MAX; carry is combinational so the chain ripples in one cycle.
module digito_bcd_crescente #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] digit,
  output logic [3:0] digit_nxt,
  output logic       carry
);

  assign carry = inc && (digit == MAX);

  // Exposed so the parent can compare against the target before the edge.
  always_comb begin
    digit_nxt = digit;
    if (clr)      digit_nxt = 4'd0;
    else if (inc) digit_nxt = (digit == MAX) ? 4'd0 : digit + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) digit <= 4'd0;
    else        digit <= digit_nxt;
  end

endmodule

// File: rtl/cronometro_bcd_crescente.sv
// mm:ss ascending BCD stopwatch with latched target, pause/resume and a done strobe.
module cronometro_bcd_crescente
  import irrigacao_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic [7:0] target_min,
  input  logic [7:0] target_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       done_pulse
);

  state_t          state, state_nxt;
  logic [7:0]      tgt_min, tgt_sec;
  logic [3:0][3:0] dig, dig_nxt;   // [0]=sec ones .. [3]=min tens
  logic [4:0]      chain;
  logic            cnt_inc, cnt_clr, accept, enter_done, unused_carry;

  assign accept  = start && !clear && target_valid(target_min, target_sec) &&
                   (state == S_IDLE || state == S_DONE);
  assign cnt_clr = clear || accept;
  assign cnt_inc = tick && !clear && (state == S_RUN);

  assign chain[0]     = cnt_inc;
  assign unused_carry = chain[4];   // 99:59 simply wraps

  generate
    for (genvar i = 0; i < 4; i++) begin : g_dig
      digito_bcd_crescente #(
        .MAX(i == 1 ? BCD_MAX_SEC_TENS : BCD_MAX_DIGIT)
      ) u_dig (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc       (chain[i]),
        .clr       (cnt_clr),
        .digit     (dig[i]),
        .digit_nxt (dig_nxt[i]),
        .carry     (chain[i+1])
      );
    end
  endgenerate

  assign min_bcd = {dig[3], dig[2]};
  assign sec_bcd = {dig[1], dig[0]};

  always_comb begin
    state_nxt  = state;
    enter_done = 1'b0;
    if (clear) begin
      state_nxt = S_IDLE;
    end else if (accept) begin
      // A zero target is already reached at 00:00.
      if (target_min == 8'h00 && target_sec == 8'h00) begin
        state_nxt  = S_DONE;
        enter_done = 1'b1;
      end else begin
        state_nxt = S_RUN;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (tick && dig_nxt == {tgt_min, tgt_sec}) begin
            state_nxt  = S_DONE;
            enter_done = 1'b1;
          end else if (pause) begin
            state_nxt = S_PAUSE;
          end
        end
        S_PAUSE: if (start) state_nxt = S_RUN;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      tgt_min    <= 8'h00;
      tgt_sec    <= 8'h00;
      running    <= 1'b0;
      done       <= 1'b0;
      done_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      running    <= (state_nxt == S_RUN);
      done       <= (state_nxt == S_DONE);
      done_pulse <= enter_done;
      if (accept) begin
        tgt_min <= target_min;
        tgt_sec <= target_sec;
      end
    end
  end

endmodule
